mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the single-ported, clocked data RAM in the execute/memory stage. It shares the RAM command port (`en`/`memwrite`/`memread`/`adr`/`writedata`, read data on `memdata`) between the CPU datapath (port C) and a peripheral master such as the VGA/game-logic reader (port P). It serialises their accesses with a req/gnt/rvalid handshake, gives the CPU priority, and bounds peripheral starvation.

## Interface
- `WIDTH`, 16, data word width.
- `RAM_ADDR_BITS`, 16, RAM address width.
- `STARVE_LIMIT`, 4, consecutive CPU wins over a pending P request before P is forced through (1..15).

- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `c_req`  in  1  CPU request; held with command until `c_gnt` sampled high.
- `c_we`  in  1  1 = write, 0 = read.
- `c_adr`  in  RAM_ADDR_BITS  CPU address.
- `c_wdata`  in  WIDTH  CPU write data.
- `c_gnt`  out  1  one-cycle pulse: CPU command issued to RAM this cycle.
- `c_rvalid`  out  1  one-cycle pulse: `c_rdata` valid.
- `c_rdata`  out  WIDTH  read data for CPU.
- `p_req`, `p_we`, `p_adr`, `p_wdata`, `p_gnt`, `p_rvalid`, `p_rdata`: same as the C port, for the peripheral.
- `en`  out  1  RAM access enable.
- `memwrite`  out  1  RAM write strobe.
- `memread`  out  1  RAM read strobe.
- `adr`  out  RAM_ADDR_BITS  RAM address.
- `writedata`  out  WIDTH  RAM write data.
- `memdata`  in  WIDTH  RAM read data; valid the cycle after the read command.

## Operation
- FSM states: IDLE, SERVE, RDWAIT. Owner register `own` (C/P); starvation counter `starve` (4 bits).
- IDLE: at the clock edge, if any req is high, pick the winner, latch its we/adr/wdata into command registers, set `own`, and go to SERVE. Otherwise stay in IDLE.
- Winner rule:
  - Only one req high → that requester wins.
  - Both high → C wins unless `starve == STARVE_LIMIT`, in which case P wins.
- `starve` update at each IDLE decision:
  - Increment if C wins while `p_req` is high.
  - Clear if P wins, or if `p_req` is low.
  - Never wraps past STARVE_LIMIT.
- SERVE (1 cycle):
  - `en=1`; `adr`/`writedata` come from the command registers.
  - `memwrite = we`, `memread = ~we`.
  - Owner's gnt is 1.
  - Next state: write → IDLE; read → RDWAIT.
- RDWAIT (1 cycle): owner's rvalid = 1, then → IDLE.
- Requests are not sampled in SERVE or RDWAIT. Requesters must drop or change their command at the edge where they sample gnt high.
- `c_rdata` and `p_rdata` are both driven directly from `memdata`; they are meaningful only while the matching rvalid is high.
- `en`, `memwrite`, `memread`, gnt and rvalid are decoded only from registered state, so they are glitch-free.
- A write is never issued when `en=0`. `memread` and `memwrite` are never high together.

## Timing
- Reset (`rst` low, async):
  - State → IDLE; `starve` and `own` cleared.
  - `c_gnt`, `p_gnt`, `c_rvalid`, `p_rvalid`, `en`, `memwrite`, `memread` = 0.
  - `adr` and `writedata` = 0.
  - An in-flight read is abandoned: no rvalid is produced after reset releases.
- Write: req sampled at edge N → gnt and RAM write during cycle N+1 → back in IDLE at N+2. Throughput is one write per 2 cycles.
- Read: req at edge N → gnt and `memread` in cycle N+1 → rvalid with data in cycle N+2 → IDLE at N+3. Throughput is one read per 3 cycles.
- Back-to-back: a request still high in IDLE is decided at the next edge. There are no bubble cycles beyond the SERVE/RDWAIT cycles above.
- Worst-case P wait under continuous CPU traffic: STARVE_LIMIT CPU transactions, then P is served.

## Test plan
- Reset mid-read: C read of adr 0x0010 is granted, and `rst` is pulsed low during RDWAIT → all outputs 0 immediately, no `c_rvalid`, FSM returns to IDLE.
- Single write then read: C writes 0xBEEF to 0x008C, then reads 0x008C → `c_gnt` one cycle after each req; `memwrite=1` with adr 0x008C in the write SERVE cycle; `c_rvalid` 2 cycles after the read req edge with `c_rdata` = 0xBEEF.
- Simultaneous requests: `c_req` and `p_req` both rise on the same edge (C write 0x0001, P read 0x0002) → C served first; P gnt arrives on the first IDLE decision after C completes; `starve` reads 1 during P's wait.
- Starvation bound: with STARVE_LIMIT=4, C requests continuously and P requests from cycle 0 → exactly 4 C grants, then `p_gnt`, then C resumes; `starve` returns to 0.
- P-only read: P reads 0x00EC while preloaded RAM holds 0x1234 → `p_gnt`, then `p_rvalid` with `p_rdata` = 0x1234; C outputs stay 0.
- Protocol checks over random traffic (1000 cycles): `memread & memwrite` never both high; gnt pulses are exactly 1 cycle; one rvalid per granted read; no `en` outside SERVE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one clocked RAM command port between the CPU (C) and a
// peripheral master (P); CPU has priority, P is forced through after STARVE_LIMIT losses.
`default_nettype none

module mem_port_arbiter #(
    parameter int WIDTH         = 16,
    parameter int RAM_ADDR_BITS = 16,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     c_req,
    input  logic                     c_we,
    input  logic [RAM_ADDR_BITS-1:0] c_adr,
    input  logic [WIDTH-1:0]         c_wdata,
    output logic                     c_gnt,
    output logic                     c_rvalid,
    output logic [WIDTH-1:0]         c_rdata,
    input  logic                     p_req,
    input  logic                     p_we,
    input  logic [RAM_ADDR_BITS-1:0] p_adr,
    input  logic [WIDTH-1:0]         p_wdata,
    output logic                     p_gnt,
    output logic                     p_rvalid,
    output logic [WIDTH-1:0]         p_rdata,
    output logic                     en,
    output logic                     memwrite,
    output logic                     memread,
    output logic [RAM_ADDR_BITS-1:0] adr,
    output logic [WIDTH-1:0]         writedata,
    input  logic [WIDTH-1:0]         memdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SERVE  = 2'd1;
    localparam logic [1:0] S_RDWAIT = 2'd2;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [1:0]               state_q, state_d;
    logic                     own_q, own_d;       // 0 = C, 1 = P
    logic [3:0]               starve_q, starve_d;
    logic                     we_q, we_d;
    logic [RAM_ADDR_BITS-1:0] adr_q, adr_d;
    logic [WIDTH-1:0]         wdata_q, wdata_d;
    logic                     p_win;

    assign p_win = p_req & (~c_req | (starve_q == STARVE_MAX));

    always_comb begin
        state_d  = state_q;
        own_d    = own_q;
        starve_d = starve_q;
        we_d     = we_q;
        adr_d    = adr_q;
        wdata_d  = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (!p_req) begin
                    starve_d = '0;
                end
                if (c_req || p_req) begin
                    state_d = S_SERVE;
                    own_d   = p_win;
                    if (p_win) begin
                        we_d     = p_we;
                        adr_d    = p_adr;
                        wdata_d  = p_wdata;
                        starve_d = '0;
                    end else begin
                        we_d    = c_we;
                        adr_d   = c_adr;
                        wdata_d = c_wdata;
                        // Count only losses that actually kept P waiting.
                        if (p_req && (starve_q != STARVE_MAX)) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                end
            end
            S_SERVE: begin
                state_d = we_q ? S_IDLE : S_RDWAIT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            own_q    <= 1'b0;
            starve_q <= '0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            own_q    <= own_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            wdata_q  <= wdata_d;
        end
    end

    // All strobes decode purely from registers so the RAM sees no glitches.
    assign en        = (state_q == S_SERVE);
    assign memwrite  = en & we_q;
    assign memread   = en & ~we_q;
    assign adr       = adr_q;
    assign writedata = wdata_q;

    assign c_gnt     = en & ~own_q;
    assign p_gnt     = en & own_q;
    assign c_rvalid  = (state_q == S_RDWAIT) & ~own_q;
    assign p_rvalid  = (state_q == S_RDWAIT) & own_q;
    assign c_rdata   = memdata;
    assign p_rdata   = memdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a behavioural RAM
// and an always-on protocol monitor.
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        c_req = 1'b0, c_we = 1'b0;
    logic [15:0] c_adr = '0, c_wdata = '0;
    logic        p_req = 1'b0, p_we = 1'b0;
    logic [15:0] p_adr = '0, p_wdata = '0;
    logic        c_gnt, c_rvalid, p_gnt, p_rvalid;
    logic [15:0] c_rdata, p_rdata;
    logic        en, memwrite, memread;
    logic [15:0] adr, writedata;
    logic [15:0] memdata = '0;

    logic [15:0] ram    [0:255];
    logic [15:0] shadow [0:255];

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    logic [15:0] exp_c[$];
    logic [15:0] exp_p[$];
    bit          glog[$];
    bit          pend_c = 0, pend_p = 0, prev_cg = 0, prev_pg = 0;

    int w0, w1, w2;
    logic [5:0] order;
    int limit;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(16), .RAM_ADDR_BITS(16), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .p_req(p_req), .p_we(p_we), .p_adr(p_adr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .en(en), .memwrite(memwrite), .memread(memread),
        .adr(adr), .writedata(writedata), .memdata(memdata)
    );

    // Clocked RAM: read data appears the cycle after the read command.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (en && memwrite) ram[adr[7:0]] <= writedata;
        if (en && memread)  memdata <= ram[adr[7:0]];
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            pend_c = 0;
            pend_p = 0;
            exp_c.delete();
            exp_p.delete();
        end
        check_val("rd_wr_excl", 32'(memread & memwrite), 0);
        check_val("en_vs_gnt", 32'(en), 32'(c_gnt | p_gnt));
        check_val("gnt_onehot", 32'(c_gnt & p_gnt), 0);
        check_val("c_gnt_pulse", 32'(prev_cg & c_gnt), 0);
        check_val("p_gnt_pulse", 32'(prev_pg & p_gnt), 0);
        check_val("c_rvalid_seq", 32'(c_rvalid), 32'(pend_c));
        check_val("p_rvalid_seq", 32'(p_rvalid), 32'(pend_p));
        if (c_gnt) begin
            check_val("c_cmd_adr", adr, c_adr);
            check_val("c_cmd_we", 32'(memwrite), 32'(c_we));
            if (c_we) check_val("c_cmd_wdata", writedata, c_wdata);
            glog.push_back(1'b0);
        end
        if (p_gnt) begin
            check_val("p_cmd_adr", adr, p_adr);
            check_val("p_cmd_we", 32'(memwrite), 32'(p_we));
            if (p_we) check_val("p_cmd_wdata", writedata, p_wdata);
            glog.push_back(1'b1);
        end
        if (c_rvalid) begin
            if (exp_c.size() == 0) check_val("c_rvalid_unexp", 32'(c_rvalid), 0);
            else check_val("c_rdata", c_rdata, exp_c.pop_front());
        end
        if (p_rvalid) begin
            if (exp_p.size() == 0) check_val("p_rvalid_unexp", 32'(p_rvalid), 0);
            else check_val("p_rdata", p_rdata, exp_p.pop_front());
        end
        pend_c  = rst & c_gnt & memread;
        pend_p  = rst & p_gnt & memread;
        prev_cg = c_gnt;
        prev_pg = p_gnt;
    end

    // Called just after a rising edge; returns how many negedges passed before gnt.
    task automatic xfer(input bit port, input bit we, input logic [15:0] a,
                        input logic [15:0] d, output int waited);
        waited = -1;
        if (!port) begin
            c_req = 1; c_we = we; c_adr = a; c_wdata = d;
            if (we) shadow[a[7:0]] = d; else exp_c.push_back(shadow[a[7:0]]);
        end else begin
            p_req = 1; p_we = we; p_adr = a; p_wdata = d;
            if (we) shadow[a[7:0]] = d; else exp_p.push_back(shadow[a[7:0]]);
        end
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (port ? p_gnt : c_gnt) begin
                waited = k;
                break;
            end
        end
        check_val(port ? "p_gnt_seen" : "c_gnt_seen", 32'(waited >= 0), 1);
        @(posedge clk);
        #1;
        if (!port) c_req = 0; else p_req = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val(tag, {en, memwrite, memread, c_gnt, p_gnt, c_rvalid, p_rvalid}, 0);
        check_val({tag, "_adr"}, adr, 0);
        check_val({tag, "_wdata"}, writedata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]    = 16'(i * 16'h0101) ^ 16'h5555;
            shadow[i] = 16'(i * 16'h0101) ^ 16'h5555;
        end
        ram[8'hEC]    = 16'h1234;
        shadow[8'hEC] = 16'h1234;

        // Reset state
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1 rst = 1;

        // Reset mid-read: pulse reset during RDWAIT
        xfer(0, 0, 16'h0010, 16'h0, w0);
        check_val("rst_rd_gnt_lat", w0, 1);
        #1 rst = 0;
        #1 check_idle_outputs("rst_mid_read");
        @(posedge clk); #1 rst = 1;
        repeat (3) begin
            @(negedge clk);
            check_val("post_rst_no_rvalid", 32'(c_rvalid), 0);
            check_val("post_rst_idle", 32'(en), 0);
        end

        // Single write then read
        @(posedge clk); #1;
        xfer(0, 1, 16'h008C, 16'hBEEF, w0);
        check_val("wr_gnt_lat", w0, 1);
        xfer(0, 0, 16'h008C, 16'h0, w0);
        check_val("rd_gnt_lat", w0, 1);
        @(negedge clk);
        check_val("rd_rvalid", 32'(c_rvalid), 1);
        check_val("rd_data", c_rdata, 16'hBEEF);

        // Simultaneous requests: C write wins, P read waits one decision
        @(posedge clk); #1;
        fork
            xfer(0, 1, 16'h0001, 16'hA5A5, w0);
            xfer(1, 0, 16'h0002, 16'h0, w1);
            begin
                repeat (2) @(negedge clk);
                check_val("starve_during_wait", 32'(dut.starve_q), 1);
            end
        join
        check_val("simul_c_lat", w0, 1);
        check_val("simul_p_lat", w1, 3);
        repeat (2) @(negedge clk);

        // Starvation bound: continuous C writes, P read pending from the start
        @(posedge clk); #1;
        glog.delete();
        fork
            begin
                for (int i = 0; i < 6; i++) xfer(0, 1, 16'(16'h0020 + i), 16'(16'h0100 + i), w2);
            end
            xfer(1, 0, 16'h00A0, 16'h0, w1);
        join
        repeat (3) @(negedge clk);
        order = '0;
        for (int i = 0; i < 6; i++) if (i < glog.size()) order[5-i] = glog[i];
        check_val("starve_order", order, 6'b000010);
        check_val("starve_p_lat", w1, 9);
        check_val("starve_cleared", 32'(dut.starve_q), 0);

        // P-only read of preloaded word
        @(posedge clk); #1;
        xfer(1, 0, 16'h00EC, 16'h0, w1);
        check_val("p_rd_gnt_lat", w1, 1);
        @(negedge clk);
        check_val("p_rd_rvalid", 32'(p_rvalid), 1);
        check_val("p_rd_data", p_rdata, 16'h1234);
        check_val("p_rd_c_quiet", {30'd0, c_gnt, c_rvalid}, 0);

        // Random traffic; C and P use disjoint address halves
        @(posedge clk); #1;
        limit = cyc + 1000;
        fork
            while (cyc < limit) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                xfer(0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 127)), 16'($urandom), w0);
            end
            while (cyc < limit) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                xfer(1, 1'($urandom_range(0, 1)), 16'($urandom_range(128, 255)), 16'($urandom), w1);
            end
        join
        repeat (4) @(negedge clk);
        check_val("c_sb_drained", exp_c.size(), 0);
        check_val("p_sb_drained", exp_p.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

`default_nettype wire
